// File: rtl/fifo_pkt_reader_if.sv
// Bundles the FIFO read port, the outgoing packet stream and the packet counter of fifo_pkt_reader.
// The master modport is the reader's view; the slave modport is the FIFO/downstream view.
interface fifo_pkt_reader_if #(
    parameter int unsigned DBITWIDTH = 32,
    parameter int unsigned CNT_BITS  = 16
);
    logic                 fifo_empty;
    logic [DBITWIDTH-1:0] fifo_read_data;
    logic                 fifo_read;
    logic                 out_valid;
    logic                 out_ready;
    logic [DBITWIDTH-1:0] out_data;
    logic                 out_sop;
    logic                 out_eop;
    logic [CNT_BITS-1:0]  pkt_count;

    modport master (
        input  fifo_empty, fifo_read_data, out_ready,
        output fifo_read, out_valid, out_data, out_sop, out_eop, pkt_count
    );

    modport slave (
        output fifo_empty, fifo_read_data, out_ready,
        input  fifo_read, out_valid, out_data, out_sop, out_eop, pkt_count
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops a clock-crossing FIFO's read port into a 2-entry buffer and tags length-framed packets with sop/eop.
// Define FIFO_PKT_READER_STATS_EN to build the completed-packet counter; otherwise pkt_count is tied to 0.
module fifo_pkt_reader #(
    parameter int unsigned DBITWIDTH = 32,
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned LEN_LSB   = 0,
    parameter int unsigned CNT_BITS  = 16
) (
    input logic               clk,
    input logic               rst,
    input logic               clr,
    fifo_pkt_reader_if.master bus
);
    typedef struct packed {
        logic [DBITWIDTH-1:0] data;
        logic                 sop;
        logic                 eop;
    } entry_t;

    typedef enum logic {HDR, PAYLOAD} state_t;

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] rem_q, rem_d, len_c;
    logic [1:0]          cnt_q, cnt_d;
    entry_t              head_q, tail_q, push_entry_c;
    logic                push_c, pop_c, tag_sop_c, tag_eop_c;

    // A full buffer may still accept a word in the cycle its head leaves.
    assign pop_c  = (cnt_q != 2'd0) & bus.out_ready;
    assign push_c = ~bus.fifo_empty & ~clr & ((cnt_q < 2'd2) | pop_c);
    assign len_c  = bus.fifo_read_data[LEN_LSB +: LEN_BITS];

    assign bus.fifo_read = push_c;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = head_q.data;
    assign bus.out_sop   = head_q.sop;
    assign bus.out_eop   = head_q.eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR;
            rem_q   <= '0;
        end else if (clr) begin
            state_q <= HDR;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Framer advances only when a word is actually taken from the FIFO.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        tag_sop_c = 1'b0;
        tag_eop_c = 1'b0;
        if (push_c) begin
            case (state_q)
                HDR: begin
                    tag_sop_c = 1'b1;
                    if (len_c == '0) begin
                        tag_eop_c = 1'b1;
                    end else begin
                        rem_d   = len_c;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (rem_q == LEN_BITS'(1)) begin
                        tag_eop_c = 1'b1;
                        state_d   = HDR;
                    end else begin
                        rem_d = rem_q - LEN_BITS'(1);
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_comb begin
        push_entry_c.data = bus.fifo_read_data;
        push_entry_c.sop  = tag_sop_c;
        push_entry_c.eop  = tag_eop_c;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_c & ~pop_c) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop_c & ~push_c) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Head is always entry 0; a pop shifts the tail forward so order is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clr) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop_c) begin
                if (cnt_q == 2'd2) begin
                    head_q <= tail_q;
                    if (push_c) begin
                        tail_q <= push_entry_c;
                    end
                end else if (push_c) begin
                    head_q <= push_entry_c;
                end
            end else if (push_c) begin
                if (cnt_q == 2'd0) begin
                    head_q <= push_entry_c;
                end else begin
                    tail_q <= push_entry_c;
                end
            end
        end
    end

`ifdef FIFO_PKT_READER_STATS_EN
    logic [CNT_BITS-1:0] pkt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else if (clr) begin
            pkt_cnt_q <= '0;
        end else if (pop_c & head_q.eop) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_BITS'(1);
        end
    end

    assign bus.pkt_count = pkt_cnt_q;
`else
    assign bus.pkt_count = CNT_BITS'(0);
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a queue models the source FIFO and a scoreboard holds expected output words.
module tb_fifo_pkt_reader;
    localparam int unsigned DW  = 32;
    localparam int unsigned CNT = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } exp_t;

    logic clk;
    logic rst;
    logic clr;
    logic stall;
    logic took;

    logic [DW-1:0] src_q[$];
    exp_t          exp_q[$];
    int            exp_pkts;
    int            rd_count;
    int            passed;
    int            total;

    fifo_pkt_reader_if #(.DBITWIDTH(DW), .CNT_BITS(CNT)) bus ();

    fifo_pkt_reader #(
        .DBITWIDTH(DW),
        .LEN_BITS (8),
        .LEN_LSB  (0),
        .CNT_BITS (CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic refresh();
        bus.fifo_empty     = stall || (src_q.size() == 0);
        bus.fifo_read_data = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic s, input logic e);
        exp_t x;
        x.data = d;
        x.sop  = s;
        x.eop  = e;
        src_q.push_back(d);
        exp_q.push_back(x);
    endtask

    task automatic load_pkt(input int len, input logic [23:0] tag);
        push_word({tag, 8'(len)}, 1'b1, len == 0);
        for (int i = 1; i <= len; i++) begin
            push_word($urandom, 1'b0, i == len);
        end
        refresh();
    endtask

    task automatic check_pkts(input string tag);
`ifdef FIFO_PKT_READER_STATS_EN
        check(tag, 64'(bus.pkt_count), 64'(CNT'(exp_pkts)));
`else
        check(tag, 64'(bus.pkt_count), 64'(0));
`endif
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (rnd) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                stall = ($urandom_range(0, 3) == 0);
                refresh();
            end
            cyc(1);
            n++;
        end
        bus.out_ready = 1'b1;
        stall = 1'b0;
        refresh();
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    // Source FIFO: pop the word the DUT took at this edge, then present the next one.
    always @(posedge clk) begin
        took = bus.fifo_read;
        #1;
        if (took) begin
            if (src_q.size() != 0) void'(src_q.pop_front());
            rd_count++;
        end
        refresh();
    end

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e.data));
                check("out_sop", 64'(bus.out_sop), 64'(e.sop));
                check("out_eop", 64'(bus.out_eop), 64'(e.eop));
                if (e.eop) exp_pkts++;
            end
        end
    end

    initial begin
        passed   = 0;
        total    = 0;
        exp_pkts = 0;
        rd_count = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        stall    = 1'b0;
        bus.out_ready = 1'b0;
        refresh();

        // Reset state
        cyc(2);
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_sop", 64'(bus.out_sop), 64'(0));
        check("rst_eop", 64'(bus.out_eop), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_read", 64'(bus.fifo_read), 64'(0));
        check("rst_pkts", 64'(bus.pkt_count), 64'(0));
        rst = 1'b0;
        cyc(1);

        // Header-only packet: one read, valid one cycle later
        bus.out_ready = 1'b1;
        load_pkt(0, 24'hA5A5A5);
        #1;
        check("hdr_only_read", 64'(bus.fifo_read), 64'(1));
        cyc(1);
        check("hdr_only_valid", 64'(bus.out_valid), 64'(1));
        check("hdr_only_sop", 64'(bus.out_sop), 64'(1));
        check("hdr_only_eop", 64'(bus.out_eop), 64'(1));
        check("hdr_only_read_off", 64'(bus.fifo_read), 64'(0));
        cyc(1);
        check_pkts("hdr_only_pkts");

        // Back-to-back packets at full rate
        load_pkt(3, 24'hB00001);
        load_pkt(1, 24'hB00002);
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            check("b2b_valid", 64'(bus.out_valid), 64'(1));
            cyc(1);
        end
        check("b2b_idle", 64'(bus.out_valid), 64'(0));
        check_pkts("b2b_pkts");

        // Backpressure: only two words enter, head holds
        bus.out_ready = 1'b0;
        rd_count = 0;
        load_pkt(4, 24'hC00001);
        cyc(6);
        check("bp_reads", 64'(rd_count), 64'(2));
        check("bp_read_off", 64'(bus.fifo_read), 64'(0));
        check("bp_valid", 64'(bus.out_valid), 64'(1));
        check("bp_head", 64'(bus.out_data), 64'(exp_q[0].data));
        cyc(2);
        check("bp_hold_data", 64'(bus.out_data), 64'(exp_q[0].data));
        check("bp_hold_sop", 64'(bus.out_sop), 64'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_release_valid", 64'(bus.out_valid), 64'(1));
            cyc(1);
        end
        check("bp_release_idle", 64'(bus.out_valid), 64'(0));
        check_pkts("bp_pkts");

        // Producer stall after payload word 2 of a len=4 packet
        push_word({24'hD00001, 8'd4}, 1'b1, 1'b0);
        push_word(32'hD0000101, 1'b0, 1'b0);
        push_word(32'hD0000102, 1'b0, 1'b0);
        refresh();
        cyc(3);
        check("stall_last_before", 64'(bus.out_valid), 64'(1));
        cyc(1);
        check("stall_gap0", 64'(bus.out_valid), 64'(0));
        cyc(1);
        check("stall_gap1", 64'(bus.out_valid), 64'(0));
        cyc(1);
        push_word(32'hD0000103, 1'b0, 1'b0);
        push_word(32'hD0000104, 1'b0, 1'b1);
        refresh();
        drain(20, 1'b0);
        check_pkts("stall_pkts");

        // Clear mid-packet: buffered words vanish, framing restarts at a header
        bus.out_ready = 1'b0;
        src_q.push_back({24'hE00001, 8'd5});
        src_q.push_back(32'hE0000101);
        refresh();
        cyc(3);
        check("clr_pre_valid", 64'(bus.out_valid), 64'(1));
        clr = 1'b1;
        src_q.delete();
        refresh();
        cyc(1);
        clr = 1'b0;
        exp_pkts = 0;
        check("clr_valid", 64'(bus.out_valid), 64'(0));
        check("clr_sop", 64'(bus.out_sop), 64'(0));
        check("clr_eop", 64'(bus.out_eop), 64'(0));
        check_pkts("clr_pkts");
        bus.out_ready = 1'b1;
        load_pkt(2, 24'hE00002);
        drain(20, 1'b0);
        check_pkts("post_clr_pkts");

        // Maximum length packet: eop exactly on word 256
        load_pkt(255, 24'hF00001);
        drain(400, 1'b0);
        check_pkts("maxlen_pkts");

        // Counter wrap: 17 packets from clear
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        exp_pkts = 0;
        for (int i = 0; i < 17; i++) begin
            load_pkt(0, 24'(i));
        end
        drain(100, 1'b0);
        cyc(1);
        check_pkts("wrap_pkts");

        // Random lengths with random backpressure and producer stalls
        for (int i = 0; i < 20; i++) begin
            load_pkt(int'($urandom_range(0, 6)), 24'h900000 + 24'(i));
        end
        drain(2000, 1'b1);
        cyc(2);
        check("rand_idle", 64'(bus.out_valid), 64'(0));
        check_pkts("rand_pkts");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Read-side consumer for the clock-crossing FIFO; sits entirely in the FIFO's read clock domain.
- Pops words from the FIFO's unregistered read port (`empty` / `read` / `read_data`) into a 2-entry output buffer.
- Frames the words into packets: header word carries the payload length.
- Presents a valid/ready stream with `sop`/`eop` to the downstream switch logic.

Parameters:
- `DBITWIDTH`, 32, bit width of FIFO data and output data.
- `LEN_BITS`, 8, width of the payload-length field in a header word.
- `LEN_LSB`, 0, LSB position of the length field in the header word; field is `[LEN_LSB+LEN_BITS-1:LEN_LSB]`.
- `CNT_BITS`, 16, width of the packet statistics counter.

Ports:
- `clk`  in  1  single clock; equals the FIFO read clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear, same effect as `rst`; must be driven together with the FIFO's read-side clear.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  `DBITWIDTH`  FIFO read data; combinational, valid in the same cycle as `fifo_read`.
- `fifo_read`  out  1  FIFO read strobe; one word popped per asserted cycle.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  `DBITWIDTH`  output word.
- `out_sop`  out  1  word is a packet header.
- `out_eop`  out  1  word is the last word of a packet.
- `pkt_count`  out  `CNT_BITS`  completed-packet counter; see Optional Feature.

Behaviour:
- **Reset / clear.** `rst` or `clr`: buffer count = 0, framer state = HDR, remaining count = 0, `pkt_count` = 0. Outputs after reset: `out_valid` = 0, `out_sop` = 0, `out_eop` = 0, `out_data` = 0, `fifo_read` = 0.
- **`fifo_read`** is combinational: `~fifo_empty & ~clr & (buf_cnt < 2 | (out_valid & out_ready))`. It never depends on `out_ready` when the buffer has space.
- **Push.** In a cycle with `fifo_read` = 1, `fifo_read_data` plus the computed `sop`/`eop` tags are written into the buffer at that clock edge.
- **Latency.** Word present with `fifo_empty` = 0 at cycle t, buffer empty → `out_valid` = 1 at t+1.
- **Throughput.** Sustained 1 word/clk when `out_ready` = 1 and the FIFO is non-empty.
- **Output buffer.** 2-entry, registered FIFO.
  - Head entry drives `out_data`, `out_sop`, `out_eop`.
  - `out_valid` = (`buf_cnt` != 0).
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop keeps `buf_cnt` unchanged and preserves order.
  - Push into a full buffer occurs only together with a pop.
- **Data stability.** While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_sop` and `out_eop` hold stable.
- **Framer.** Evaluated only on push cycles.
  - State HDR: tag `sop` = 1; `len` = length field of the word.
    - `len` == 0 → tag `eop` = 1, stay in HDR.
    - Otherwise `rem` ← `len`, go to PAYLOAD.
  - State PAYLOAD: tag `sop` = 0.
    - `rem` == 1 → tag `eop` = 1, go to HDR.
    - Otherwise `eop` = 0; `rem` ← `rem` − 1.
  - Maximum packet length is 2^`LEN_BITS` − 1 payload words plus the header word.
- **Clear mid-packet.** Clear while in PAYLOAD discards the partial framing; the next pushed word is treated as a header. Buffered words are dropped; no `eop` is generated for the truncated packet.
- **FIFO empty.** `fifo_empty` = 1 → no read; framer and `rem` hold. Stalls inside a packet are allowed at any word.

Optional Feature:
- Macro: `FIFO_PKT_READER_STATS_EN`.
- **Defined:** `pkt_count` increments by 1 on every output handshake (`out_valid & out_ready`) with `out_eop` = 1.
  - Wraps modulo 2^`CNT_BITS`.
  - Cleared by `rst` / `clr`.
- **Undefined:** `pkt_count` is tied to 0 and no counter logic is built.

Test Plan:
- **Single header-only packet.** Reset; FIFO holds header with `len` = 0; `out_ready` = 1 → `fifo_read` high 1 cycle; next cycle `out_valid` = 1 with `sop` = 1, `eop` = 1; `pkt_count` = 1 (stats on).
- **Back-to-back packets.** FIFO holds `len` = 3 packet then `len` = 1 packet (6 words); `out_ready` = 1 → 6 consecutive valid cycles; `sop` on words 0 and 4; `eop` on words 3 and 5; `pkt_count` = 2.
- **Backpressure.** FIFO holds 5 words; `out_ready` = 0 → exactly 2 reads, then `fifo_read` = 0 with `out_data` stable; raise `out_ready` → remaining 3 words read and delivered in order with no gap.
- **Producer stall mid-packet.** `len` = 4 packet with `fifo_empty` = 1 for 3 cycles after payload word 2 → `out_valid` drops; framing resumes; `eop` only on payload word 4.
- **Clear mid-packet.** `clr` pulse after header + 1 payload of a `len` = 5 packet → `out_valid` = 0 next cycle; next word is tagged `sop` = 1 and its length field is honoured.
- **Wrap / max length.** `LEN_BITS` = 8, `len` = 255 packet → `eop` on 256th word exactly. With stats on and `CNT_BITS` = 4, 17 packets → `pkt_count` = 1.
